// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded instruction fields in, stall and forwarding selects out.
// master = ID/decode side, slave = pipe_hazard_scoreboard.
interface pipe_hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic              sb_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_regwrite, id_memread, flush,
        input  stall, fwd_sel_a, fwd_sel_b, sb_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_regwrite, id_memread, flush,
        output stall, fwd_sel_a, fwd_sel_b, sb_busy
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writers: ID-stage stall and registered EX forwarding selects.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter output (stall_cnt).
module pipe_hazard_scoreboard #(
    parameter int STAGES     = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipe_hazard_scoreboard_if.slave  bus
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_ld;
    logic [REG_AW-1:0] r_rd [STAGES];
    logic [SEL_W-1:0]  r_fwd_a;
    logic [SEL_W-1:0]  r_fwd_b;

    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_nr_a;
    logic              w_nr_b;
    logic [SEL_W-1:0]  w_sel_a;
    logic [SEL_W-1:0]  w_sel_b;
    logic              w_stall;
    logic              w_issue;

    // Scan oldest to youngest so the lowest matching index is what remains.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_nr_a  = 1'b0;
        w_nr_b  = 1'b0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (r_v[k] && (r_rd[k] == bus.id_rs) && (bus.id_rs != '0)) begin
                w_hit_a = 1'b1;
                w_sel_a = SEL_W'(k + 1);
                w_nr_a  = r_ld[k] && (k < LOAD_READY);
            end
            if (r_v[k] && (r_rd[k] == bus.id_rt) && (bus.id_rt != '0)) begin
                w_hit_b = 1'b1;
                w_sel_b = SEL_W'(k + 1);
                w_nr_b  = r_ld[k] && (k < LOAD_READY);
            end
        end
    end

    // Flush masks the stall: a killed instruction must never hold the front end.
    assign w_stall = bus.id_valid && !bus.flush &&
                     ((bus.id_use_rs && w_nr_a) || (bus.id_use_rt && w_nr_b));
    assign w_issue = bus.id_valid && !bus.flush && !w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v     <= '0;
            r_ld    <= '0;
            r_fwd_a <= '0;
            r_fwd_b <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                r_v[k]  <= r_v[k-1];
                r_ld[k] <= r_ld[k-1];
                r_rd[k] <= r_rd[k-1];
            end
            r_v[0]  <= w_issue && bus.id_regwrite && (bus.id_rd != '0);
            r_ld[0] <= bus.id_memread;
            r_rd[0] <= bus.id_rd;
            r_fwd_a <= (w_issue && bus.id_use_rs && w_hit_a) ? w_sel_a : '0;
            r_fwd_b <= (w_issue && bus.id_use_rt && w_hit_b) ? w_sel_b : '0;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.stall     = w_stall;
    assign bus.fwd_sel_a = r_fwd_a;
    assign bus.fwd_sel_b = r_fwd_b;
    assign bus.sb_busy   = |r_v;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Scoreboard-driven bench for pipe_hazard_scoreboard: LOAD_READY=1 instance (u_dut0) and LOAD_READY=2 instance (u_dut1).
module tb_pipe_hazard_scoreboard;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic [5:0] exp;   // {stall, fwd_sel_a, fwd_sel_b, sb_busy}
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.REG_AW(5), .SEL_W(2)) if0 ();
    pipe_hazard_scoreboard_if #(.REG_AW(5), .SEL_W(2)) if1 ();

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] cnt0;
    logic [31:0] cnt1;
`endif

    pipe_hazard_scoreboard #(.STAGES(3), .REG_AW(5), .LOAD_READY(1), .SEL_W(2)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt (cnt0)
`endif
    );

    pipe_hazard_scoreboard #(.STAGES(3), .REG_AW(5), .LOAD_READY(2), .SEL_W(2)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt (cnt1)
`endif
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] q[$];
    logic       o_stall;
    logic [1:0] o_fa;
    logic [1:0] o_fb;
    logic       o_busy;

    function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic urs,
                                 input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic fl,
                                 input logic est, input logic [1:0] efa, input logic [1:0] efb,
                                 input logic ebusy);
        stim_t s;
        s.rst = 1'b0; s.v = v; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
        s.rd = rd; s.rw = rw; s.mr = mr; s.fl = fl;
        s.exp = {est, efa, efb, ebusy};
        return s;
    endfunction

    function automatic stim_t mk_rst();
        stim_t s;
        s = mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic drive(input int sel, input stim_t s);
        if (sel == 0) begin
            if0.id_valid = s.v;  if0.id_rs = s.rs; if0.id_use_rs = s.urs;
            if0.id_rt = s.rt;    if0.id_use_rt = s.urt; if0.id_rd = s.rd;
            if0.id_regwrite = s.rw; if0.id_memread = s.mr; if0.flush = s.fl;
        end else begin
            if1.id_valid = s.v;  if1.id_rs = s.rs; if1.id_use_rs = s.urs;
            if1.id_rt = s.rt;    if1.id_use_rt = s.urt; if1.id_rd = s.rd;
            if1.id_regwrite = s.rw; if1.id_memread = s.mr; if1.flush = s.fl;
        end
    endtask

    task automatic idle_all();
        stim_t s;
        s = mk_rst();
        drive(0, s);
        drive(1, s);
    endtask

    task automatic do_reset();
        idle_all();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Stall is sampled mid-cycle; forwarding selects and busy just after the next edge.
    task automatic step(input int sel, input stim_t s);
        drive(sel, s);
        #1;
        o_stall = (sel == 0) ? if0.stall : if1.stall;
        @(posedge clk);
        #1;
        o_fa   = (sel == 0) ? if0.fwd_sel_a : if1.fwd_sel_a;
        o_fb   = (sel == 0) ? if0.fwd_sel_b : if1.fwd_sel_b;
        o_busy = (sel == 0) ? if0.sb_busy   : if1.sb_busy;
    endtask

    task automatic test_reset();
        stim_t s;
        do_reset();
        step(0, mk(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 1));
        step(0, mk(1, 5'd3, 1, 0, 0, 5'd5, 1, 1, 0, 0, 1, 0, 1));
        n_tests++;
        if ({o_stall, o_fa, o_fb, o_busy} !== 6'b0_01_00_1) begin
            n_fail++;
            $display("FAIL reset_pre_fwd got %b exp %b", {o_stall, o_fa, o_fb, o_busy}, 6'b0_01_00_1);
        end
        s = mk(1, 0, 0, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, 0, 0);
        drive(0, s);
        #1;
        n_tests++;
        if ({if0.stall, if0.fwd_sel_a, if0.fwd_sel_b, if0.sb_busy} !== 6'b1_01_00_1) begin
            n_fail++;
            $display("FAIL reset_pre_stall got %b exp %b",
                     {if0.stall, if0.fwd_sel_a, if0.fwd_sel_b, if0.sb_busy}, 6'b1_01_00_1);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({if0.stall, if0.fwd_sel_a, if0.fwd_sel_b, if0.sb_busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async got %b exp %b",
                     {if0.stall, if0.fwd_sel_a, if0.fwd_sel_b, if0.sb_busy}, 6'b0);
        end
        rst_n = 1'b1;
        do_reset();
    endtask

    task automatic test_forward();
        stim_t s[$];
        logic [5:0] e;
        s.push_back(mk_rst());
        s.push_back(mk(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 5'd3, 1, 0, 0, 5'd10, 1, 0, 0, 0, 1, 0, 1));
        s.push_back(mk_rst());
        s.push_back(mk(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk_rst());
        s.push_back(mk(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0, 3, 0));
        s.push_back(mk(1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            if (s[i].rst) begin do_reset(); continue; end
            q.push_back(s[i].exp);
            step(0, s[i]);
            e = q.pop_front();
            n_tests++;
            if ({o_stall, o_fa, o_fb, o_busy} !== e) begin
                n_fail++;
                $display("FAIL forward[%0d] got %b exp %b", i, {o_stall, o_fa, o_fb, o_busy}, e);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [5:0] e;
        s.push_back(mk_rst());
        s.push_back(mk(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 5'd5, 1, 5'd6, 1, 0, 0, 1, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, 2, 1));
        foreach (s[i]) begin
            if (s[i].rst) begin do_reset(); continue; end
            q.push_back(s[i].exp);
            step(0, s[i]);
            e = q.pop_front();
            n_tests++;
            if ({o_stall, o_fa, o_fb, o_busy} !== e) begin
                n_fail++;
                $display("FAIL load_use_lr1[%0d] got %b exp %b", i, {o_stall, o_fa, o_fb, o_busy}, e);
            end
        end
    endtask

    task automatic test_load_use_lr2();
        stim_t s[$];
        logic [5:0] e;
        s.push_back(mk_rst());
        s.push_back(mk(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 5'd5, 1, 5'd6, 1, 0, 0, 1, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 5'd5, 1, 5'd6, 1, 0, 0, 1, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, 3, 1));
        foreach (s[i]) begin
            if (s[i].rst) begin do_reset(); continue; end
            q.push_back(s[i].exp);
            step(1, s[i]);
            e = q.pop_front();
            n_tests++;
            if ({o_stall, o_fa, o_fb, o_busy} !== e) begin
                n_fail++;
                $display("FAIL load_use_lr2[%0d] got %b exp %b", i, {o_stall, o_fa, o_fb, o_busy}, e);
            end
        end
    endtask

    task automatic test_zero_and_youngest();
        stim_t s[$];
        logic [5:0] e;
        s.push_back(mk_rst());
        s.push_back(mk(1, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk_rst());
        s.push_back(mk(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        foreach (s[i]) begin
            if (s[i].rst) begin do_reset(); continue; end
            q.push_back(s[i].exp);
            step(0, s[i]);
            e = q.pop_front();
            n_tests++;
            if ({o_stall, o_fa, o_fb, o_busy} !== e) begin
                n_fail++;
                $display("FAIL zero_youngest[%0d] got %b exp %b", i, {o_stall, o_fa, o_fb, o_busy}, e);
            end
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        logic [5:0] e;
        s.push_back(mk_rst());
        s.push_back(mk(1, 0, 0, 0, 0, 5'd4, 1, 1, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 5'd4, 1, 0, 0, 5'd8, 1, 0, 1, 0, 0, 0, 1));
        s.push_back(mk(1, 5'd4, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
        foreach (s[i]) begin
            if (s[i].rst) begin do_reset(); continue; end
            q.push_back(s[i].exp);
            step(0, s[i]);
            e = q.pop_front();
            n_tests++;
            if ({o_stall, o_fa, o_fb, o_busy} !== e) begin
                n_fail++;
                $display("FAIL flush[%0d] got %b exp %b", i, {o_stall, o_fa, o_fb, o_busy}, e);
            end
        end
    endtask

`ifdef HAZARD_STALL_CNT_EN
    task automatic test_stall_cnt();
        stim_t s[$];
        logic [5:0] e;
        for (int p = 0; p < 3; p++) begin
            s.push_back(mk(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0, 0, 0, 1));
            s.push_back(mk(1, 0, 0, 5'd5, 1, 5'd6, 1, 0, 0, 1, 0, 0, 1));
            s.push_back(mk(1, 0, 0, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, 2, 1));
        end
        do_reset();
        foreach (s[i]) begin
            q.push_back(s[i].exp);
            step(0, s[i]);
            e = q.pop_front();
            n_tests++;
            if ({o_stall, o_fa, o_fb, o_busy} !== e) begin
                n_fail++;
                $display("FAIL stall_cnt_seq[%0d] got %b exp %b", i, {o_stall, o_fa, o_fb, o_busy}, e);
            end
        end
        n_tests++;
        if (cnt0 !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_cnt_three got %0d exp 3", cnt0);
        end
        u_dut0.r_stall_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 6; i++) begin
            step(0, s[i]);
        end
        n_tests++;
        if (cnt0 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL stall_cnt_sat got %h exp ffffffff", cnt0);
        end
    endtask
`endif

    initial begin
        idle_all();
        test_reset();
        test_forward();
        test_load_use();
        test_load_use_lr2();
        test_zero_and_youngest();
        test_flush();
`ifdef HAZARD_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
